// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants: opcodes, instruction types, ALU codes, funct7 values.
// Also used by the control decoder and its benches.
package rv_enc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_R    = 3'd0,
    TYPE_I    = 3'd1,
    TYPE_S    = 3'd2,
    TYPE_B    = 3'd3,
    TYPE_U    = 3'd4,
    TYPE_J    = 3'd5,
    TYPE_RSV6 = 3'd6,
    TYPE_RSV7 = 3'd7
  } instr_type_e;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd9;

  // Field bundle held in stage 1
  typedef struct packed {
    instr_type_e      itype;
    logic [OP_W-1:0]  op;
    logic             sub;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic             err;
  } fields_t;

  function automatic logic [F3_W-1:0] alu_funct3(input logic [OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SUB: alu_funct3 = 3'b000;
      ALU_SLL:          alu_funct3 = 3'b001;
      ALU_SLT:          alu_funct3 = 3'b010;
      ALU_SLTU:         alu_funct3 = 3'b011;
      ALU_XOR:          alu_funct3 = 3'b100;
      ALU_SRL, ALU_SRA: alu_funct3 = 3'b101;
      ALU_OR:           alu_funct3 = 3'b110;
      ALU_AND:          alu_funct3 = 3'b111;
      default:          alu_funct3 = 3'b000;
    endcase
  endfunction

  function automatic logic alu_is_shift(input logic [OP_W-1:0] op);
    alu_is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic alu_is_alt(input logic [OP_W-1:0] op);
    alu_is_alt = (op == ALU_SUB) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Scatters a byte-offset immediate into its RV32I instruction bit positions; all other bits zero.
module rv_imm_pack
  import rv_enc_pkg::*;
(
  input  instr_type_e     itype,
  input  logic            shamt,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] imm_bits_c
);

  always_comb begin
    imm_bits_c = '0;
    case (itype)
      TYPE_I: begin
        if (shamt) imm_bits_c[24:20] = imm[4:0];
        else       imm_bits_c[31:20] = imm[11:0];
      end
      TYPE_S: begin
        imm_bits_c[31:25] = imm[11:5];
        imm_bits_c[11:7]  = imm[4:0];
      end
      TYPE_B: begin
        imm_bits_c[31]    = imm[12];
        imm_bits_c[30:25] = imm[10:5];
        imm_bits_c[11:8]  = imm[4:1];
        imm_bits_c[7]     = imm[11];
      end
      TYPE_U: imm_bits_c[31:12] = imm[31:12];
      TYPE_J: begin
        imm_bits_c[31]    = imm[20];
        imm_bits_c[30:21] = imm[10:1];
        imm_bits_c[20]    = imm[11];
        imm_bits_c[19:12] = imm[19:12];
      end
      default: imm_bits_c = '0;
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: stage 1 registers fields, stage 2 the packed word.
// Define ENC_CHECK_EN to flag illegal bundles (emitted as NOP with out_err=1).
module rv_instr_encoder
  import rv_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_sub,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_word,
  output logic              out_err
);

  fields_t           s1_q;
  logic              s1_valid;
  logic              s1_adv_c;
  logic              s2_adv_c;
  logic              accept_c;
  logic              chk_err_c;
  logic              shamt_c;
  logic              nop_c;
  logic [OPC_W-1:0]  opc_c;
  logic [F3_W-1:0]   f3_c;
  logic [F7_W-1:0]   f7_c;
  logic [REG_W-1:0]  rd_c;
  logic [REG_W-1:0]  rs1_c;
  logic [REG_W-1:0]  rs2_c;
  logic [XLEN-1:0]   imm_bits_c;
  logic [XLEN-1:0]   word_c;

  assign s2_adv_c = !out_valid || out_ready;
  assign s1_adv_c = s1_valid && s2_adv_c;
  assign in_ready = !rst && (!s1_valid || s1_adv_c);
  assign accept_c = in_valid && in_ready;

`ifdef ENC_CHECK_EN
  logic fits12_c;
  logic fits13_c;
  logic fits21_c;

  // Signed-range tests: all bits above the field's sign bit must match it
  assign fits12_c = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits13_c = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign fits21_c = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    chk_err_c = 1'b0;
    case (instr_type_e'(in_type))
      TYPE_R: chk_err_c = (in_op > ALU_AND);
      TYPE_I: begin
        if (in_sub)
          chk_err_c = (in_op[2:0] == 3'd3) || (in_op[2:0] == 3'd6) ||
                      (in_op[2:0] == 3'd7) || !fits12_c;
        else
          chk_err_c = (in_op > ALU_AND) || (in_op == ALU_SUB) || !fits12_c ||
                      (alu_is_shift(in_op) && (|in_imm[11:5]));
      end
      TYPE_S: chk_err_c = (in_op[2:0] > 3'd2) || !fits12_c;
      TYPE_B: chk_err_c = (in_op[2:0] == 3'd2) || (in_op[2:0] == 3'd3) ||
                          !fits13_c || in_imm[0];
      TYPE_U: chk_err_c = |in_imm[11:0];
      TYPE_J: chk_err_c = !fits21_c || in_imm[0];
      default: chk_err_c = 1'b1;
    endcase
  end
`else
  assign chk_err_c = 1'b0;
`endif

  assign shamt_c = (s1_q.itype == TYPE_I) && !s1_q.sub && alu_is_shift(s1_q.op);

  rv_imm_pack u_imm_pack (
    .itype      (s1_q.itype),
    .shamt      (shamt_c),
    .imm        (s1_q.imm),
    .imm_bits_c (imm_bits_c)
  );

  // Non-immediate fields per format; unused register fields stay zero
  always_comb begin
    opc_c = '0;
    f3_c  = '0;
    f7_c  = '0;
    rd_c  = '0;
    rs1_c = '0;
    rs2_c = '0;
    nop_c = 1'b0;
    case (s1_q.itype)
      TYPE_R: begin
        opc_c = OPC_R;
        f3_c  = alu_funct3(s1_q.op);
        f7_c  = alu_is_alt(s1_q.op) ? F7_ALT : F7_BASE;
        rd_c  = s1_q.rd;
        rs1_c = s1_q.rs1;
        rs2_c = s1_q.rs2;
      end
      TYPE_I: begin
        rd_c  = s1_q.rd;
        rs1_c = s1_q.rs1;
        if (s1_q.sub) begin
          opc_c = OPC_LOAD;
          f3_c  = s1_q.op[2:0];
        end else begin
          opc_c = OPC_IMM;
          f3_c  = alu_funct3(s1_q.op);
          if (shamt_c && (s1_q.op == ALU_SRA)) f7_c = F7_ALT;
        end
      end
      TYPE_S: begin
        opc_c = OPC_STORE;
        f3_c  = s1_q.op[2:0];
        rs1_c = s1_q.rs1;
        rs2_c = s1_q.rs2;
      end
      TYPE_B: begin
        opc_c = OPC_BRANCH;
        f3_c  = s1_q.op[2:0];
        rs1_c = s1_q.rs1;
        rs2_c = s1_q.rs2;
      end
      TYPE_U: begin
        opc_c = s1_q.sub ? OPC_AUIPC : OPC_LUI;
        rd_c  = s1_q.rd;
      end
      TYPE_J: begin
        opc_c = OPC_JAL;
        rd_c  = s1_q.rd;
      end
      default: nop_c = 1'b1;
    endcase
  end

  assign word_c = (nop_c || s1_q.err) ? NOP_WORD
                : (imm_bits_c | {f7_c, rs2_c, rs1_c, f3_c, rd_c, opc_c});

  // Pipeline registers; stage 2 holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_err   <= 1'b0;
    end else begin
      if (accept_c) begin
        s1_valid <= 1'b1;
        s1_q     <= '{itype: instr_type_e'(in_type), op: in_op, sub: in_sub,
                      rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm,
                      err: chk_err_c};
      end else if (s1_adv_c) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv_c) out_valid <= s1_valid;
      if (s1_adv_c) begin
        out_word <= word_c;
        out_err  <= s1_q.err;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed bundles checked against a field-level encoding model.
module tb_rv_instr_encoder;

`ifdef ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_type = '0;
  logic [3:0]  in_op = '0;
  logic        in_sub = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_lat = -1;
  bit saw_stall = 1'b0;
  bit held = 1'b0;
  logic [31:0] held_word;
  logic        held_err;
  logic [32:0] exp_q[$];
  int          cyc_q[$];

  rv_instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_op     (in_op),
    .in_sub    (in_sub),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Returns {err, word} built from the ISA field layout with integer arithmetic
  function automatic logic [32:0] model(input int t, input int op, input int sub,
                                        input int rd, input int rs1, input int rs2,
                                        input logic [31:0] imm);
    int unsigned u, w;
    int s, f3, f7, g;
    bit bad;
    u = imm;
    s = $signed(imm);
    w = 0;
    bad = 1'b0;
    g = op % 8;
    case (op)
      2: f3 = 1;  3: f3 = 2;  4: f3 = 3;  5: f3 = 4;
      6: f3 = 5;  7: f3 = 5;  8: f3 = 6;  9: f3 = 7;
      default: f3 = 0;
    endcase
    f7 = (op == 1 || op == 7) ? 32 : 0;
    case (t)
      0: begin
        w = 'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
        bad = (op > 9);
      end
      1: begin
        if (sub != 0) begin
          w = 'h03 | (rd << 7) | (g << 12) | (rs1 << 15) | ((u % 4096) << 20);
          bad = (g == 3) || (g == 6) || (g == 7) || (s < -2048) || (s > 2047);
        end else if (op == 2 || op == 6 || op == 7) begin
          w = 'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((u % 32) << 20) | (f7 << 25);
          bad = (((u >> 5) % 128) != 0) || (s < -2048) || (s > 2047);
        end else begin
          w = 'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((u % 4096) << 20);
          bad = (op > 9) || (op == 1) || (s < -2048) || (s > 2047);
        end
      end
      2: begin
        w = 'h23 | ((u % 32) << 7) | (g << 12) | (rs1 << 15) | (rs2 << 20) |
            (((u >> 5) % 128) << 25);
        bad = (g > 2) || (s < -2048) || (s > 2047);
      end
      3: begin
        w = 'h63 | (((u >> 11) % 2) << 7) | (((u >> 1) % 16) << 8) | (g << 12) |
            (rs1 << 15) | (rs2 << 20) | (((u >> 5) % 64) << 25) | (((u >> 12) % 2) << 31);
        bad = (g == 2) || (g == 3) || (s < -4096) || (s > 4095) || ((u % 2) != 0);
      end
      4: begin
        w = ((sub != 0) ? 'h17 : 'h37) | (rd << 7) | ((u >> 12) << 12);
        bad = (u % 4096) != 0;
      end
      5: begin
        w = 'h6F | (rd << 7) | (((u >> 12) % 256) << 12) | (((u >> 11) % 2) << 20) |
            (((u >> 1) % 1024) << 21) | (((u >> 20) % 2) << 31);
        bad = (s < -1048576) || (s > 1048575) || ((u % 2) != 0);
      end
      default: begin
        w = 'h13;
        bad = 1'b1;
      end
    endcase
    if (CHECK_EN && bad) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  task automatic pin(input string name, input int t, input int op, input int sub,
                     input int rd, input int rs1, input int rs2, input logic [31:0] imm,
                     input logic [31:0] exp_word, input logic exp_err);
    logic [32:0] m;
    m = model(t, op, sub, rd, rs1, rs2, imm);
    check(name, m, {exp_err, exp_word});
  endtask

  task automatic send(input int t, input int op, input int sub, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_type = 3'(t);
    in_op = 4'(op);
    in_sub = 1'(sub);
    in_rd = 5'(rd);
    in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2);
    in_imm = imm;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=no_accept expected=accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d_pending expected=0", exp_q.size());
    end
  endtask

  // Per-cycle compare: scoreboard on output handshakes, hold stability while stalled
  always @(negedge clk) begin
    logic [32:0] e;
    int pc;
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      held = 1'b0;
      check("rst_in_ready", 33'(in_ready), 33'd0);
    end else begin
      if (held) begin
        check("hold_valid", 33'(out_valid), 33'd1);
        check("hold_word", {1'b0, out_word}, {1'b0, held_word});
        check("hold_err", 33'(out_err), 33'(held_err));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_word got=%h expected=none", out_word);
        end else begin
          e = exp_q.pop_front();
          pc = cyc_q.pop_front();
          if (first_lat < 0) first_lat = cyc - pc;
          check("out_word", {1'b0, out_word}, {1'b0, e[31:0]});
          check("out_err", 33'(out_err), 33'(e[32]));
        end
      end
      held = out_valid && !out_ready;
      held_word = out_word;
      held_err = out_err;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(in_type), int'(in_op), int'(in_sub), int'(in_rd),
                              int'(in_rs1), int'(in_rs2), in_imm));
        cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Model pinned against hand-encoded words
    pin("pin_add",   0, 0, 0, 5, 21, 4, 32'd0, 32'h004A_82B3, 1'b0);
    pin("pin_sub",   0, 1, 0, 6, 21, 5, 32'd0, 32'h405A_8333, 1'b0);
    pin("pin_addi",  1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    pin("pin_lui",   4, 0, 0, 13, 0, 0, 32'h0F56_B000, 32'h0F56_B6B7, 1'b0);
    pin("pin_beq",   3, 0, 0, 7, 1, 2, 32'd8, 32'h0020_8463, 1'b0);
    pin("pin_sw",    2, 2, 0, 9, 2, 5, 32'hFFFF_FFFC, 32'hFE51_2E23, 1'b0);
    pin("pin_jal",   5, 0, 0, 1, 3, 0, 32'd2048, 32'h0010_00EF, 1'b0);
    if (CHECK_EN) begin
      pin("pin_isub_err", 1, 1, 0, 1, 2, 0, 32'd0, 32'h0000_0013, 1'b1);
      pin("pin_b7_err",   3, 0, 0, 0, 1, 2, 32'd7, 32'h0000_0013, 1'b1);
    end

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("reset_valid", 33'(out_valid), 33'd0);
    check("reset_word", {1'b0, out_word}, 33'd0);
    check("reset_err", 33'(out_err), 33'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // First bundle alone gives the unloaded latency
    send(0, 0, 0, 5, 21, 4, 32'd0);
    wait_drain();
    check("latency", 33'(first_lat), 33'd2);

    send(0, 1, 0, 6, 21, 5, 32'd0);
    send(1, 0, 0, 1, 0, 7, 32'hFFFF_FFFF);
    send(4, 0, 0, 13, 9, 9, 32'h0F56_B000);
    send(3, 0, 0, 7, 1, 2, 32'd8);
    send(2, 2, 0, 9, 2, 5, 32'hFFFF_FFFC);
    send(1, 7, 0, 3, 4, 11, 32'd5);
    send(1, 2, 1, 8, 2, 0, 32'd100);
    send(4, 0, 1, 2, 0, 0, 32'hFFFF_F000);
    send(5, 0, 0, 1, 3, 4, 32'd2048);
    send(0, 9, 0, 10, 11, 12, 32'd0);
    send(3, 1, 0, 0, 3, 4, 32'hFFFF_FFF8);
    send(3, 4, 0, 0, 5, 6, 32'hFFFF_F000);
    send(5, 0, 0, 31, 0, 0, 32'hFFF0_0000);
    send(1, 8, 0, 4, 5, 0, 32'd2047);
    wait_drain();

    // Backpressure: four back-to-back bundles with output stalled three cycles
    fork
      begin
        send(0, 5, 0, 1, 2, 3, 32'd0);
        send(1, 8, 0, 2, 3, 0, 32'h0000_07FF);
        send(2, 0, 0, 0, 4, 5, 32'hFFFF_F800);
        send(3, 7, 0, 0, 6, 7, 32'd4094);
      end
      begin
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check("in_ready_dropped", 33'(saw_stall), 33'd1);

    if (CHECK_EN) begin
      send(1, 1, 0, 1, 2, 0, 32'd0);
      send(3, 0, 0, 0, 1, 2, 32'd7);
      send(1, 3, 1, 1, 2, 0, 32'd0);
      send(4, 0, 0, 1, 0, 0, 32'h0000_1001);
      send(6, 0, 0, 1, 1, 1, 32'd0);
      wait_drain();
    end

    // Reset with both stages full drops in-flight words
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(0, 0, 0, 1, 1, 1, 32'd0);
    send(0, 1, 0, 2, 2, 2, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", 33'(out_valid), 33'd0);
    send(0, 8, 0, 7, 8, 9, 32'd0);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
